// File: rtl/cbi980_pkg.sv
// Shared constants and types for the CBI980 I2S transmitter.
// Used by the top (cbi980_i2s_tx) and the optional sample FIFO (cbi980_sync_fifo).
package cbi980_pkg;

    localparam int SLOT_LAST   = 31;
    localparam int SAMPLE_W    = 16;
    localparam int FRAME_W     = 32;
    localparam int LR_HI_FIRST = 15;
    localparam int LR_HI_LAST  = 30;
    localparam int LEVEL_W     = 5;

    typedef logic [4:0]         slot_t;
    typedef logic [FRAME_W-1:0] frame_t;

    // lrclk leads the data by one slot, so it is high for slots 15..30
    function automatic logic lrclk_for_slot(input slot_t s);
        return (s >= slot_t'(LR_HI_FIRST)) && (s <= slot_t'(LR_HI_LAST));
    endfunction

endpackage

// File: rtl/cbi980_sync_fifo.sv
// Single-clock sample FIFO with occupancy count; DEPTH must be a power of two.
// Used by cbi980_i2s_tx only when CBI980_TX_FIFO_EN is defined.
module cbi980_sync_fifo
    import cbi980_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic               aclk,
    input  logic               arstn,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   pop_data,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [LEVEL_W-1:0] level_q;
    logic               do_push;
    logic               do_pop;

    // no bypass: a full FIFO refuses a push even if it is popped in the same cycle
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LEVEL_W'(1);
                2'b01:   level_q <= level_q - LEVEL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (level_q == LEVEL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;

endmodule

// File: rtl/cbi980_i2s_tx.sv
// I2S master transmitter: sample buffer, bclk divider, 32-slot frame serializer.
// Define CBI980_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module cbi980_i2s_tx
    import cbi980_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               aclk,
    input  logic               arstn,
    input  logic               en,
    input  logic [FRAME_W-1:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               urun_clr,
    output logic [LEVEL_W-1:0] level,
    output logic               urun,
    output logic               irq,
    output logic               i2s_bclk,
    output logic               i2s_lrclk,
    output logic               i2s_sdata
);

    localparam int DIV_W = 8;

    logic [1:0]       rst_sync;
    logic             rst_n;
    logic [DIV_W-1:0] div_q;
    logic             bclk_q;
    logic             lrclk_q;
    logic             sdata_q;
    logic             urun_q;
    slot_t            slot_q;
    slot_t            slot_nxt;
    frame_t           shreg_q;
    frame_t           frame_in;
    frame_t           head_data;
    logic             head_empty;
    logic             div_wrap;
    logic             bclk_fall;
    logic             slot0_entry;

    // assert asynchronously, release two aclk edges after arstn rises
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign div_wrap    = (div_q == DIV_W'(CLK_DIV - 1));
    assign bclk_fall   = en & div_wrap & bclk_q;
    assign slot_nxt    = (slot_q == slot_t'(SLOT_LAST)) ? '0 : slot_q + slot_t'(1);
    assign slot0_entry = bclk_fall & (slot_q == slot_t'(SLOT_LAST));
    assign frame_in    = head_empty ? '0 : head_data;

`ifdef CBI980_TX_FIFO_EN
    logic fifo_full;

    cbi980_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_W)
    ) u_fifo (
        .aclk      (aclk),
        .arstn     (rst_n),
        .push      (s_valid),
        .push_data (s_data),
        .pop       (slot0_entry),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (head_empty),
        .level     (level)
    );

    assign s_ready = ~fifo_full;
`else
    // FIFO_DEPTH has no effect in the single-register build
    localparam int DEPTH_EFF = 1 + 0 * FIFO_DEPTH;

    logic   hold_valid;
    frame_t hold_data;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (s_valid && s_ready) begin
            hold_valid <= 1'b1;
            hold_data  <= s_data;
        end else if (slot0_entry) begin
            hold_valid <= 1'b0;
        end
    end

    assign level      = LEVEL_W'(hold_valid);
    assign s_ready    = (level != LEVEL_W'(DEPTH_EFF));
    assign head_empty = ~hold_valid;
    assign head_data  = hold_data;
`endif

    // dropping en abandons the frame; buffered samples stay put
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            bclk_q  <= 1'b0;
            slot_q  <= slot_t'(SLOT_LAST);
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            shreg_q <= '0;
        end else if (!en) begin
            div_q   <= '0;
            bclk_q  <= 1'b0;
            slot_q  <= slot_t'(SLOT_LAST);
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
        end else if (div_wrap) begin
            div_q  <= '0;
            bclk_q <= ~bclk_q;
            if (bclk_q) begin
                slot_q  <= slot_nxt;
                lrclk_q <= lrclk_for_slot(slot_nxt);
                if (slot0_entry) begin
                    sdata_q <= frame_in[FRAME_W-1];
                    shreg_q <= {frame_in[FRAME_W-2:0], 1'b0};
                end else begin
                    sdata_q <= shreg_q[FRAME_W-1];
                    shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
                end
            end
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // a new underrun takes priority over a coincident clear
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n)                        urun_q <= 1'b0;
        else if (slot0_entry & head_empty) urun_q <= 1'b1;
        else if (urun_clr)                 urun_q <= 1'b0;
    end

    assign urun      = urun_q;
    assign irq       = urun_q;
    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;
    assign i2s_sdata = sdata_q;

endmodule
